// File: rtl/sr_task_queue_array.sv
// Sorted shift-register task queue. Cells stay packed in ascending key order, and
// keys count down on tick. A per-task sched bit decides which entry the dispatcher sees.
module sr_task_queue_array #(
  parameter int DEPTH = 8,
  parameter int TID_W = 4,
  parameter int KEY_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [TID_W-1:0] cmd_tid,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic             cmd_blk,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [TID_W-1:0] resp_tid,
  output logic [KEY_W-1:0] resp_key,
  output logic             head_valid,
  output logic [TID_W-1:0] head_tid,
  output logic [KEY_W-1:0] head_key,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [1:0] OP_SET = 2'b11;

  logic [TID_W-1:0] tid_q [DEPTH];
  logic [KEY_W-1:0] key_q [DEPTH];
  logic [DEPTH-1:0] sched_q;
  logic [CNT_W-1:0] count_q;

  logic [DEPTH-1:0] valid;
  logic [KEY_W-1:0] key_post [DEPTH];
  logic [TID_W-1:0] sr_tid [DEPTH], sl_tid [DEPTH], n_tid [DEPTH];
  logic [KEY_W-1:0] sr_key [DEPTH], sl_key [DEPTH], n_key [DEPTH];
  logic [DEPTH-1:0] sr_sched, sl_sched, n_sched;
  logic             head_found, hit_found;
  logic [IDX_W-1:0] head_idx, hit_idx, del_idx;
  logic [CNT_W-1:0] ins_idx;
  logic             do_ins, do_del, do_set;
  logic             rsp_err;
  logic [TID_W-1:0] rsp_tid;
  logic [KEY_W-1:0] rsp_key;

  // Lookups all run on post-tick keys, so insertion sees the same keys that get stored.
  always_comb begin
    head_found = 1'b0;
    head_idx   = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    ins_idx    = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]    = CNT_W'(i) < count_q;
      key_post[i] = (valid[i] && tick && key_q[i] != '0) ? key_q[i] - KEY_W'(1) : key_q[i];
      if (valid[i] && sched_q[i] && !head_found) begin
        head_found = 1'b1;
        head_idx   = IDX_W'(i);
      end
      if (valid[i] && tid_q[i] == cmd_tid && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (valid[i] && key_post[i] > cmd_key && ins_idx == count_q) ins_idx = CNT_W'(i);
    end
  end

  always_comb begin
    do_ins  = 1'b0;
    do_del  = 1'b0;
    do_set  = 1'b0;
    del_idx = '0;
    rsp_err = 1'b0;
    rsp_tid = cmd_tid;
    rsp_key = '0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_ENQ: if (full || hit_found) rsp_err = 1'b1; else do_ins = 1'b1;
        OP_DEQ: begin
          if (!head_found) rsp_err = 1'b1;
          else begin
            do_del  = 1'b1;
            del_idx = head_idx;
            rsp_tid = tid_q[head_idx];
            rsp_key = key_post[head_idx];
          end
        end
        OP_REM: begin
          if (!hit_found) rsp_err = 1'b1;
          else begin
            do_del  = 1'b1;
            del_idx = hit_idx;
          end
        end
        default: if (!hit_found) rsp_err = 1'b1; else do_set = 1'b1;
      endcase
    end
  end

  always_comb begin
    sr_tid[0]           = '0;
    sr_key[0]           = '0;
    sl_tid[DEPTH-1]     = '0;
    sl_key[DEPTH-1]     = '0;
    sr_sched            = {sched_q[DEPTH-2:0], 1'b0};
    sl_sched            = {1'b0, sched_q[DEPTH-1:1]};
    for (int i = 1; i < DEPTH; i++) begin
      sr_tid[i] = tid_q[i-1];
      sr_key[i] = key_post[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      sl_tid[i] = tid_q[i+1];
      sl_key[i] = key_post[i+1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_tid[i]   = tid_q[i];
      n_key[i]   = key_post[i];
      n_sched[i] = sched_q[i];
      if (do_ins && CNT_W'(i) == ins_idx) begin
        n_tid[i]   = cmd_tid;
        n_key[i]   = cmd_key;
        n_sched[i] = ~cmd_blk;
      end else if (do_ins && CNT_W'(i) > ins_idx) begin
        n_tid[i]   = sr_tid[i];
        n_key[i]   = sr_key[i];
        n_sched[i] = sr_sched[i];
      end
      if (do_del && IDX_W'(i) >= del_idx) begin
        n_tid[i]   = sl_tid[i];
        n_key[i]   = sl_key[i];
        n_sched[i] = sl_sched[i];
      end
      if (do_set && IDX_W'(i) == hit_idx) n_sched[i] = ~cmd_blk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tid_q[i] <= '0;
        key_q[i] <= '0;
      end
      sched_q    <= '0;
      count_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_tid   <= '0;
      resp_key   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tid_q[i] <= n_tid[i];
        key_q[i] <= n_key[i];
      end
      sched_q    <= n_sched;
      if (do_ins) count_q <= count_q + CNT_W'(1);
      else if (do_del) count_q <= count_q - CNT_W'(1);
      resp_valid <= cmd_valid;
      resp_err   <= cmd_valid & rsp_err;
      resp_tid   <= cmd_valid ? rsp_tid : '0;
      resp_key   <= cmd_valid ? rsp_key : '0;
    end
  end

  assign head_valid = head_found;
  assign head_tid   = head_found ? tid_q[head_idx] : '0;
  assign head_key   = head_found ? key_q[head_idx] : '0;
  assign count      = count_q;
  assign empty      = count_q == '0;
  assign full       = count_q == CNT_W'(DEPTH);
endmodule

// File: tb/tb_sr_task_queue_array.sv
// Bench for sr_task_queue_array: directed scenarios plus a randomized run,
// all checked against a queue-based ordered-list model.
module tb_sr_task_queue_array;
  localparam int DEPTH = 8;
  localparam int TID_W = 4;
  localparam int KEY_W = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, tick, cmd_valid, cmd_blk;
  logic [1:0]       cmd_op;
  logic [TID_W-1:0] cmd_tid;
  logic [KEY_W-1:0] cmd_key;
  logic             resp_valid, resp_err, head_valid, empty, full;
  logic [TID_W-1:0] resp_tid, head_tid;
  logic [KEY_W-1:0] resp_key, head_key;
  logic [CNT_W-1:0] count;

  sr_task_queue_array #(.DEPTH(DEPTH), .TID_W(TID_W), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_tid(cmd_tid), .cmd_key(cmd_key), .cmd_blk(cmd_blk), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_tid(resp_tid), .resp_key(resp_key), .head_valid(head_valid),
    .head_tid(head_tid), .head_key(head_key), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TID_W-1:0] tid;
    logic [KEY_W-1:0] key;
    logic             sched;
  } ent_t;

  ent_t             mq[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic             exp_rv, exp_err;
  logic [TID_W-1:0] exp_rtid;
  logic [KEY_W-1:0] exp_rkey;
  logic [1:0]       last_op;

  function automatic int m_find(input logic [TID_W-1:0] t);
    foreach (mq[i]) if (mq[i].tid == t) return i;
    return -1;
  endfunction

  function automatic int m_head();
    foreach (mq[i]) if (mq[i].sched) return i;
    return -1;
  endfunction

  // Drive one cycle, advance the model by the same command, sample #1 after the edge.
  task automatic cmd(input bit v, input logic [1:0] op, input logic [TID_W-1:0] t,
                     input logic [KEY_W-1:0] k, input bit b, input bit tk);
    int   idx;
    ent_t e;
    cmd_valid = v; cmd_op = op; cmd_tid = t; cmd_key = k; cmd_blk = b; tick = tk;
    last_op = op;
    foreach (mq[i]) if (tk && mq[i].key != 0) mq[i].key = mq[i].key - 1;
    exp_rv = v; exp_err = 1'b0; exp_rtid = t; exp_rkey = '0;
    if (v) begin
      case (op)
        2'b00: begin
          if (mq.size() == DEPTH || m_find(t) >= 0) exp_err = 1'b1;
          else begin
            idx = mq.size();
            for (int i = 0; i < mq.size(); i++) if (mq[i].key > k) begin idx = i; break; end
            e.tid = t; e.key = k; e.sched = !b;
            mq.insert(idx, e);
          end
        end
        2'b01: begin
          idx = m_head();
          if (idx < 0) exp_err = 1'b1;
          else begin
            exp_rtid = mq[idx].tid; exp_rkey = mq[idx].key;
            mq.delete(idx);
          end
        end
        2'b10: begin
          idx = m_find(t);
          if (idx < 0) exp_err = 1'b1; else mq.delete(idx);
        end
        default: begin
          idx = m_find(t);
          if (idx < 0) exp_err = 1'b1; else mq[idx].sched = !b;
        end
      endcase
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tid = 4'd5; cmd_key = 32'd3; cmd_blk = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    mq.delete();
    if ({resp_valid, resp_err, resp_tid, resp_key, head_valid, head_tid, head_key, count, full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rv=%0b err=%0b rtid=%0d rkey=%0d hv=%0b htid=%0d hkey=%0d cnt=%0d full=%0b exp all 0",
               resp_valid, resp_err, resp_tid, resp_key, head_valid, head_tid, head_key, count, full);
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    n_checks++;
    cmd_valid = 1'b0; tick = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_enqueue_order();
    logic [TID_W-1:0] ord [3];
    logic [KEY_W-1:0] keys [3];
    ord = '{4'd1, 4'd7, 4'd3};
    keys = '{32'd10, 32'd25, 32'd40};
    cmd(1, 2'b00, 4'd3, 32'd40, 0, 0);
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL enq1_err got=%0b exp=0", resp_err); end
    n_checks++;
    cmd(1, 2'b00, 4'd1, 32'd10, 0, 0);
    cmd(1, 2'b00, 4'd7, 32'd25, 0, 0);
    if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL enq3_resp got rv=%0b err=%0b exp rv=1 err=0", resp_valid, resp_err);
    end
    n_checks++;
    if (head_tid !== 4'd1 || head_key !== 32'd10 || count !== 4'd3) begin
      n_fail++; $display("FAIL enq_head got tid=%0d key=%0d cnt=%0d exp tid=1 key=10 cnt=3", head_tid, head_key, count);
    end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
      if (resp_err !== 1'b0 || resp_tid !== ord[i] || resp_key !== keys[i]) begin
        n_fail++; $display("FAIL enq_order[%0d] got err=%0b tid=%0d key=%0d exp err=0 tid=%0d key=%0d",
                           i, resp_err, resp_tid, resp_key, ord[i], keys[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_tie_and_dup();
    cmd(1, 2'b00, 4'd1, 32'd10, 0, 0);
    cmd(1, 2'b00, 4'd2, 32'd10, 0, 0);
    cmd(1, 2'b00, 4'd1, 32'd5, 0, 0);
    if (resp_err !== 1'b1 || count !== 4'd2) begin
      n_fail++; $display("FAIL dup_enq got err=%0b cnt=%0d exp err=1 cnt=2", resp_err, count);
    end
    n_checks++;
    cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
    if (resp_tid !== 4'd1) begin n_fail++; $display("FAIL tie_first got=%0d exp=1", resp_tid); end
    n_checks++;
    cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
    if (resp_tid !== 4'd2 || empty !== 1'b1) begin
      n_fail++; $display("FAIL tie_second got tid=%0d empty=%0b exp tid=2 empty=1", resp_tid, empty);
    end
    n_checks++;
  endtask

  task automatic test_tick();
    logic [TID_W-1:0] ord [3];
    logic [KEY_W-1:0] keys [3];
    cmd(1, 2'b00, 4'd1, 32'd10, 0, 0);
    cmd(1, 2'b00, 4'd2, 32'd25, 0, 0);
    for (int i = 0; i < 12; i++) cmd(0, 2'b00, 4'd0, 32'd0, 0, 1);
    if (head_tid !== 4'd1 || head_key !== 32'd0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL tick_sat got tid=%0d key=%0d rv=%0b exp tid=1 key=0 rv=0", head_tid, head_key, resp_valid);
    end
    n_checks++;
    cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
    cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
    if (resp_tid !== 4'd2 || resp_key !== 32'd13) begin
      n_fail++; $display("FAIL tick_second got tid=%0d key=%0d exp tid=2 key=13", resp_tid, resp_key);
    end
    n_checks++;
    cmd(1, 2'b00, 4'd1, 32'd6, 0, 0);
    cmd(1, 2'b00, 4'd2, 32'd20, 0, 0);
    cmd(1, 2'b00, 4'd3, 32'd5, 0, 1);
    ord = '{4'd1, 4'd3, 4'd2};
    keys = '{32'd5, 32'd5, 32'd19};
    for (int i = 0; i < 3; i++) begin
      cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
      if (resp_tid !== ord[i] || resp_key !== keys[i]) begin
        n_fail++; $display("FAIL tick_insert[%0d] got tid=%0d key=%0d exp tid=%0d key=%0d",
                           i, resp_tid, resp_key, ord[i], keys[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_block();
    cmd(1, 2'b00, 4'd1, 32'd10, 0, 0);
    cmd(1, 2'b00, 4'd2, 32'd20, 0, 0);
    cmd(1, 2'b00, 4'd3, 32'd30, 0, 0);
    cmd(1, 2'b11, 4'd1, 32'd0, 1, 0);
    if (head_tid !== 4'd2 || head_key !== 32'd20) begin
      n_fail++; $display("FAIL block_head got tid=%0d key=%0d exp tid=2 key=20", head_tid, head_key);
    end
    n_checks++;
    cmd(1, 2'b11, 4'd2, 32'd0, 1, 0);
    cmd(1, 2'b11, 4'd3, 32'd0, 1, 0);
    if (head_valid !== 1'b0) begin n_fail++; $display("FAIL block_all got hv=%0b exp=0", head_valid); end
    n_checks++;
    cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
    if (resp_err !== 1'b1 || count !== 4'd3) begin
      n_fail++; $display("FAIL block_deq got err=%0b cnt=%0d exp err=1 cnt=3", resp_err, count);
    end
    n_checks++;
    cmd(1, 2'b11, 4'd1, 32'd0, 0, 0);
    if (head_valid !== 1'b1 || head_tid !== 4'd1) begin
      n_fail++; $display("FAIL activate got hv=%0b tid=%0d exp hv=1 tid=1", head_valid, head_tid);
    end
    n_checks++;
    for (int t = 1; t <= 3; t++) cmd(1, 2'b10, TID_W'(t), 32'd0, 0, 0);
  endtask

  task automatic test_full();
    logic [TID_W-1:0] mid;
    for (int t = 0; t < DEPTH; t++) cmd(1, 2'b00, TID_W'(t), KEY_W'($urandom_range(1, 100)), 0, 0);
    if (full !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL fill got full=%0b cnt=%0d exp full=1 cnt=8", full, count);
    end
    n_checks++;
    cmd(1, 2'b00, 4'd9, 32'd1, 0, 0);
    if (resp_err !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL over_full got err=%0b cnt=%0d exp err=1 cnt=8", resp_err, count);
    end
    n_checks++;
    mid = mq[3].tid;
    cmd(1, 2'b10, mid, 32'd0, 0, 0);
    if (resp_err !== 1'b0 || resp_tid !== mid || full !== 1'b0 || count !== 4'd7) begin
      n_fail++; $display("FAIL remove_mid got err=%0b tid=%0d full=%0b cnt=%0d exp err=0 tid=%0d full=0 cnt=7",
                         resp_err, resp_tid, full, count, mid);
    end
    n_checks++;
    cmd(1, 2'b10, 4'd9, 32'd0, 0, 0);
    if (resp_err !== 1'b1) begin n_fail++; $display("FAIL remove_absent got err=%0b exp=1", resp_err); end
    n_checks++;
    for (int i = 0; i < 7; i++) begin
      cmd(1, 2'b01, 4'd0, 32'd0, 0, 0);
      if (resp_err !== 1'b0 || resp_tid !== exp_rtid || resp_key !== exp_rkey) begin
        n_fail++; $display("FAIL drain[%0d] got err=%0b tid=%0d key=%0d exp err=0 tid=%0d key=%0d",
                           i, resp_err, resp_tid, resp_key, exp_rtid, exp_rkey);
      end
      n_checks++;
    end
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL drain_empty got empty=%0b cnt=%0d exp empty=1 cnt=0", empty, count);
    end
    n_checks++;
  endtask

  task automatic test_random();
    int               r, h;
    logic [1:0]       op;
    logic             ehv;
    logic [TID_W-1:0] etid;
    logic [KEY_W-1:0] ekey;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 40) ? 2'b00 : (r < 65) ? 2'b01 : (r < 80) ? 2'b10 : 2'b11;
      cmd($urandom_range(0, 99) < 85, op, TID_W'($urandom_range(0, 9)), KEY_W'($urandom_range(0, 30)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 40);
      h = m_head();
      ehv = h >= 0;
      etid = ehv ? mq[h].tid : '0;
      ekey = ehv ? mq[h].key : '0;
      if (resp_valid !== exp_rv || (exp_rv && resp_err !== exp_err)) begin
        n_fail++; $display("FAIL rnd_resp[%0d] got rv=%0b err=%0b exp rv=%0b err=%0b", n, resp_valid, resp_err, exp_rv, exp_err);
      end
      n_checks++;
      if (exp_rv && !(exp_err && last_op == 2'b01)) begin
        if (resp_tid !== exp_rtid || resp_key !== exp_rkey) begin
          n_fail++; $display("FAIL rnd_data[%0d] got tid=%0d key=%0d exp tid=%0d key=%0d", n, resp_tid, resp_key, exp_rtid, exp_rkey);
        end
        n_checks++;
      end
      if (head_valid !== ehv || head_tid !== etid || head_key !== ekey) begin
        n_fail++; $display("FAIL rnd_head[%0d] got hv=%0b tid=%0d key=%0d exp hv=%0b tid=%0d key=%0d",
                           n, head_valid, head_tid, head_key, ehv, etid, ekey);
      end
      n_checks++;
      if (count !== CNT_W'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_count[%0d] got cnt=%0d empty=%0b full=%0b exp cnt=%0d", n, count, empty, full, mq.size());
      end
      n_checks++;
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_tid = '0; cmd_key = '0; cmd_blk = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_enqueue_order();
    test_tie_and_dup();
    test_tick();
    test_block();
    test_full();
    test_random();
    cmd(1, 2'b00, 4'd12, 32'd7, 0, 0);
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
